// File: rtl/uart_tx_if.sv
// uart_tx_if: valid/ready byte input, busy flag and serial line for uart_tx.
// The master side is the byte producer; the slave side is the transmitter.
interface uart_tx_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       busy;
    logic       txd;

    modport master (output data, valid, input ready, busy, txd);
    modport slave  (input data, valid, output ready, busy, txd);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: 8-bit async serial transmitter (start, 8 data LSB first, optional parity, 1-2 stop).
// Define UART_TX_PARITY_EN to build the parity bit; PARITY_ODD selects its polarity.
module uart_tx #(
    parameter int CLKS_PER_BIT = 264,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    uart_tx_if.slave bus
);
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [1:0]  STOP_LAST = 2'(STOP_BITS);

    generate
        if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks
            $error("uart_tx: CLKS_PER_BIT must be 2..65535");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("uart_tx: STOP_BITS must be 1 or 2");
        end
        if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity
            $error("uart_tx: PARITY_ODD must be 0 or 1");
        end
    endgenerate

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t      state, state_next;
    logic [15:0] baud, baud_next;
    logic [2:0]  bit_idx, bit_next;
    logic [1:0]  stop_cnt, stop_next;
    logic [7:0]  shift, shift_next;
    logic        txd_q, txd_next;
    logic        bit_done;
`ifdef UART_TX_PARITY_EN
    logic        par_q, par_next;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state    <= IDLE;
            baud     <= '0;
            bit_idx  <= '0;
            stop_cnt <= '0;
            shift    <= '0;
            txd_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state    <= state_next;
            baud     <= baud_next;
            bit_idx  <= bit_next;
            stop_cnt <= stop_next;
            shift    <= shift_next;
            txd_q    <= txd_next;
`ifdef UART_TX_PARITY_EN
            par_q    <= par_next;
`endif
        end
    end

    // The line level is registered from the next state so txd never glitches.
    always_comb begin
        state_next = state;
        baud_next  = baud;
        bit_next   = bit_idx;
        stop_next  = stop_cnt;
        shift_next = shift;
        txd_next   = 1'b1;
`ifdef UART_TX_PARITY_EN
        par_next   = par_q;
`endif
        bit_done   = (baud == BAUD_LAST);

        if (state != IDLE) begin
            baud_next = bit_done ? '0 : baud + 16'd1;
        end

        case (state)
            IDLE: begin
                if (bus.valid) begin
                    state_next = START;
                    shift_next = bus.data;
                    baud_next  = '0;
`ifdef UART_TX_PARITY_EN
                    par_next   = (^bus.data) ^ (PARITY_ODD != 0);
`endif
                end
            end
            START: begin
                if (bit_done) begin
                    state_next = DATA;
                    bit_next   = 3'd0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_idx == 3'd7) begin
                        bit_next   = 3'd0;
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
                        stop_next  = 2'd1;
`endif
                    end else begin
                        bit_next   = bit_idx + 3'd1;
                        shift_next = shift >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    state_next = STOP;
                    stop_next  = 2'd1;
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    if (stop_cnt == STOP_LAST) begin
                        state_next = IDLE;
                    end else begin
                        stop_next = stop_cnt + 2'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        case (state_next)
            START:   txd_next = 1'b0;
            DATA:    txd_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  txd_next = par_next;
`endif
            default: txd_next = 1'b1;
        endcase
    end

    assign bus.ready = (state == IDLE);
    assign bus.busy  = (state != IDLE);
    assign bus.txd   = txd_q;
endmodule
